// File: rtl/read_domain_arbiter.sv
// Round-robin read-side scheduler: drains several FWFT FIFOs in bursts into one
// registered valid/ready output stage tagged with the source channel.
module read_domain_arbiter #(
  parameter  int num_channels = 4,
  parameter  int data_width   = 8,
  parameter  int max_burst    = 4,
  localparam int chan_w       = $clog2(num_channels)
) (
  input  logic                               read_clk,
  input  logic                               rreset_n,
  input  logic [num_channels-1:0]            chan_enable,
  input  logic [num_channels-1:0]            chan_empty,
  input  logic [num_channels*data_width-1:0] chan_rdata,
  output logic [num_channels-1:0]            chan_read_incr,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [data_width-1:0]              out_data,
  output logic [chan_w-1:0]                  out_chan,
  output logic                               busy
);

  localparam int cnt_w = $clog2(max_burst + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_next;
  logic [chan_w-1:0]       rr_ptr, grant, sel_idx, grant_inc;
  logic [cnt_w-1:0]        burst_cnt;
  logic [num_channels-1:0] eligible;
  logic                    found, load, pop, last_word, burst_end;

  assign eligible  = chan_enable & ~chan_empty;
  assign load      = ~out_valid | out_ready;
  assign pop       = (state == GRANT) & load & chan_enable[grant] & ~chan_empty[grant];
  assign last_word = (int'(burst_cnt) + 1 == max_burst);
  // A grant ends either on its last counted word or on any load cycle that moved nothing.
  assign burst_end = (state == GRANT) & load & (~pop | last_word);
  assign grant_inc = (int'(grant) == num_channels - 1) ? '0 : grant + 1'b1;

  // First eligible channel at or above rr_ptr, wrapping around.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < num_channels; k++) begin
      if (!found && eligible[(int'(rr_ptr) + k) % num_channels]) begin
        found   = 1'b1;
        sel_idx = chan_w'((int'(rr_ptr) + k) % num_channels);
      end
    end
  end

  always_ff @(posedge read_clk or negedge rreset_n) begin
    if (!rreset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = GRANT;
      GRANT:   if (burst_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state == GRANT);
    chan_read_incr = '0;
    for (int i = 0; i < num_channels; i++) begin
      chan_read_incr[i] = pop & (int'(grant) == i) & rreset_n;
    end
  end

  always_ff @(posedge read_clk or negedge rreset_n) begin
    if (!rreset_n) begin
      rr_ptr    <= '0;
      grant     <= '0;
      burst_cnt <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant     <= sel_idx;
        burst_cnt <= '0;
      end
      if (pop) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (burst_end) begin
        rr_ptr <= grant_inc;
      end
    end
  end

  // A pop refills the stage even while the old word is leaving, giving back-to-back transfers.
  always_ff @(posedge read_clk or negedge rreset_n) begin
    if (!rreset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= chan_rdata[int'(grant)*data_width +: data_width];
      out_chan  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_domain_arbiter.sv
// Directed bench for read_domain_arbiter: four modelled FWFT FIFOs feed the
// arbiter and each cycle's output is compared against hand-computed traces.
module tb_read_domain_arbiter;

  logic        read_clk;
  logic        rreset_n;
  logic [3:0]  chan_enable;
  logic [3:0]  chan_empty;
  logic [31:0] chan_rdata;
  logic [3:0]  chan_read_incr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        busy;

  int vectors;
  int miscompares;

  logic [7:0] mem [4][64];
  int         wr_ptr [4];
  int         rd_ptr [4];

  logic [15:0] exp_q  [$];
  logic [3:0]  incr_q [$];
  bit          rdy_q  [$];

  read_domain_arbiter #(.num_channels(4), .data_width(8), .max_burst(4)) dut (
    .read_clk       (read_clk),
    .rreset_n       (rreset_n),
    .chan_enable    (chan_enable),
    .chan_empty     (chan_empty),
    .chan_rdata     (chan_rdata),
    .chan_read_incr (chan_read_incr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_chan       (out_chan),
    .busy           (busy)
  );

  initial begin
    read_clk = 1'b0;
    forever #5 read_clk = ~read_clk;
  end

  for (genvar g = 0; g < 4; g++) begin : g_rdata
    assign chan_rdata[g*8 +: 8] = mem[g][rd_ptr[g] % 64];
  end

  // FIFO read side: registered empty flag that already reflects this cycle's pop.
  always @(posedge read_clk or negedge rreset_n) begin
    if (!rreset_n) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i]     <= wr_ptr[i];
        chan_empty[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        int nxt;
        nxt = rd_ptr[i] + (chan_read_incr[i] ? 1 : 0);
        rd_ptr[i]     <= nxt;
        chan_empty[i] <= (nxt == wr_ptr[i]);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] en);
    out_ready   = 1'b1;
    chan_enable = en;
    @(negedge read_clk);
    rreset_n = 1'b0;
    repeat (2) @(negedge read_clk);
    rreset_n = 1'b1;
  endtask

  task automatic loadFifo(input int ch, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      mem[ch][(wr_ptr[ch] + k) % 64] = first + 8'(k);
    end
    wr_ptr[ch] = wr_ptr[ch] + n;
  endtask

  task automatic runTrace(input string name);
    logic [15:0] code;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge read_clk);
      code = {3'b000, busy, (out_valid ? {2'b10, out_chan, out_data} : 12'h000)};
      checkOutput($sformatf("%s[%0d]", name, k), {16'h0, code}, {16'h0, exp_q[k]});
      if (incr_q.size() > k) begin
        checkOutput($sformatf("%s_incr[%0d]", name, k), {28'h0, chan_read_incr}, {28'h0, incr_q[k]});
      end
      if (rdy_q.size() > k) begin
        out_ready = rdy_q[k];
      end
    end
    incr_q.delete();
    rdy_q.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rreset_n    = 1'b0;
    out_ready   = 1'b1;
    chan_enable = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wr_ptr[i] = 0;
      for (int j = 0; j < 64; j++) mem[i][j] = 8'h00;
    end
    #12;
    checkOutput("reset_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_busy",  {31'h0, busy}, 32'h0);
    checkOutput("reset_incr",  {28'h0, chan_read_incr}, 32'h0);
    checkOutput("reset_data",  {24'h0, out_data}, 32'h0);
    checkOutput("reset_chan",  {30'h0, out_chan}, 32'h0);

    // Single channel: four back-to-back words, one idle cycle, then the remainder.
    applyStimulus(4'b1111);
    loadFifo(1, 8'h11, 6);
    exp_q = '{16'h0000, 16'h1000, 16'h1911, 16'h1912, 16'h1913, 16'h0914,
              16'h1000, 16'h1915, 16'h1916, 16'h0000};
    runTrace("single");

    // One word per channel: grants rotate 0,1,2,3.
    applyStimulus(4'b1111);
    loadFifo(0, 8'hA0, 1);
    loadFifo(1, 8'hA1, 1);
    loadFifo(2, 8'hA2, 1);
    loadFifo(3, 8'hA3, 1);
    exp_q = '{16'h0000, 16'h1000, 16'h18A0, 16'h0000, 16'h1000, 16'h19A1, 16'h0000,
              16'h1000, 16'h1AA2, 16'h0000, 16'h1000, 16'h1BA3, 16'h0000};
    runTrace("rrobin");

    // Backpressure for five edges mid-burst.
    applyStimulus(4'b1111);
    loadFifo(0, 8'h21, 8);
    exp_q  = '{16'h0000, 16'h1000, 16'h1821, 16'h1822, 16'h1822, 16'h1822, 16'h1822,
               16'h1822, 16'h1822, 16'h1823, 16'h0824, 16'h1000, 16'h1825};
    incr_q = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1};
    rdy_q  = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    runTrace("bpress");

    // ch2 empties after two words; the next grant starts at ch3.
    applyStimulus(4'b1111);
    loadFifo(2, 8'h31, 2);
    loadFifo(3, 8'h41, 2);
    exp_q = '{16'h0000, 16'h1000, 16'h1A31, 16'h1A32, 16'h0000, 16'h1000,
              16'h1B41, 16'h1B42, 16'h0000};
    runTrace("early");

    // Only ch0 and ch2 enabled: grants alternate and wrap past the disabled ones.
    applyStimulus(4'b0101);
    loadFifo(0, 8'h50, 5);
    loadFifo(1, 8'h70, 1);
    loadFifo(2, 8'h60, 5);
    loadFifo(3, 8'h80, 1);
    exp_q = '{16'h0000, 16'h1000, 16'h1850, 16'h1851, 16'h1852, 16'h0853,
              16'h1000, 16'h1A60, 16'h1A61, 16'h1A62, 16'h0A63, 16'h1000,
              16'h1854, 16'h0000, 16'h1000, 16'h1A64, 16'h0000, 16'h0000};
    runTrace("disable");
    checkOutput("ch1_not_popped", 32'(wr_ptr[1] - rd_ptr[1]), 32'd1);
    checkOutput("ch3_not_popped", 32'(wr_ptr[3] - rd_ptr[3]), 32'd1);

    // Reset in the middle of a burst.
    applyStimulus(4'b1111);
    loadFifo(1, 8'h71, 8);
    loadFifo(3, 8'h91, 4);
    exp_q = '{16'h0000, 16'h1000, 16'h1971, 16'h1972};
    runTrace("preRst");
    #2 rreset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("midrst_busy",  {31'h0, busy}, 32'h0);
    checkOutput("midrst_incr",  {28'h0, chan_read_incr}, 32'h0);
    @(negedge read_clk);
    rreset_n = 1'b1;
    loadFifo(3, 8'hB1, 2);
    loadFifo(1, 8'hA1, 2);
    exp_q = '{16'h0000, 16'h1000, 16'h19A1, 16'h19A2};
    runTrace("postRst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/read_domain_arbiter.md
Name: read_domain_arbiter

Overview:
Read-side round-robin scheduler that shares one downstream stream between num_channels async FIFOs in the read_clk domain. Each FIFO read port supplies a registered empty flag and first-word-fall-through read data. The block drives each FIFO's read_incr and forwards words into a single registered valid/ready output stage tagged with the source channel. Grants are held for bursts of up to max_burst words to amortise the arbitration cycle.

Parameters:
num_channels, 4, number of FIFO read ports; legal range 2..16, need not be a power of two.
data_width, 8, FIFO word width.
max_burst, 4, maximum words popped per grant; legal range 1..16.
chan_w, $clog2(num_channels), derived width of the channel index; not overridable.

Ports:
read_clk  input  1  read-domain clock; all state on its rising edge.
rreset_n  input  1  asynchronous active-low reset.
chan_enable  input  num_channels  per-channel eligibility, quasi-static configuration.
chan_empty  input  num_channels  per-channel FIFO empty flag, registered at the FIFO.
chan_rdata  input  num_channels*data_width  per-channel FIFO head word; channel i occupies bits [i*data_width +: data_width].
chan_read_incr  output  num_channels  per-channel pop strobe, combinational, at most one bit high.
out_valid  output  1  output stage holds a word.
out_ready  input  1  downstream accepts the word.
out_data  output  data_width  forwarded word, registered.
out_chan  output  chan_w  source channel of out_data, registered.
busy  output  1  high while the FSM is in GRANT.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, rr_ptr=0, grant=0, burst_cnt=0.
  - out_valid=0, out_data=0, out_chan=0, busy=0.
  - chan_read_incr=0 while rreset_n is low.
- Definitions:
  - eligible[i] = chan_enable[i] & ~chan_empty[i].
  - load = ~out_valid | out_ready.
- IDLE state:
  - No pops occur.
  - If any channel is eligible, select the first eligible index searching upward from rr_ptr, wrapping modulo num_channels.
  - On selection: grant<=index, burst_cnt<=0, go to GRANT. The arbitration costs one cycle.
  - If no channel is eligible, remain in IDLE.
- GRANT state:
  - pop = load & chan_enable[grant] & ~chan_empty[grant].
  - chan_read_incr[grant] = pop; all other bits are 0.
  - On pop: out_data<=chan_rdata[grant], out_chan<=grant, out_valid<=1, burst_cnt<=burst_cnt+1.
  - Count end: on a pop with burst_cnt+1==max_burst, go to IDLE and set rr_ptr<=(grant+1) mod num_channels.
  - Early end: if load & ~pop (channel went empty or was disabled), go to IDLE and set rr_ptr<=(grant+1) mod num_channels. No word moves in that cycle.
  - Stall: if ~load, hold state, burst_cnt and all outputs. No pop occurs, even if the channel has data.
- Output stage:
  - If out_valid & out_ready & ~pop, then out_valid<=0.
  - Holding rules while out_valid & ~out_ready: out_data and out_chan hold stable.
  - Same-cycle handoff: on out_ready in the same cycle as a pop, the new word replaces the old one with out_valid staying 1, giving back-to-back transfers.
- FIFO interaction:
  - chan_empty updates one cycle after a pop and already reflects that pop, so no extra pop-gating is needed.
  - A pop is never issued into an empty FIFO.
- Throughput: with out_ready held high, a grant delivers max_burst words in max_burst consecutive cycles, followed by one IDLE cycle.
- Fairness: a channel that stays eligible is granted at least once every num_channels grants.
- Width rule: rr_ptr and grant wrap modulo num_channels and never reach num_channels.
- Disable mid-burst: the burst ends on the first load cycle after chan_enable[grant] falls. Words already in the output stage are still delivered.
- Reset mid-burst: the output word in flight is discarded. FIFO pointers reset independently on the same rreset_n.

Test Plan:
- Single channel: ch1 holds 0x11..0x16, out_ready=1, max_burst=4. Expect out_data 0x11..0x14 with out_chan=1 on 4 consecutive cycles, then one idle cycle, then 0x15,0x16.
- Round-robin: all 4 channels non-empty, max_burst=1. Expect out_chan sequence 0,1,2,3,0,1 with one bubble between words.
- Backpressure: out_ready=0 for 5 cycles mid-burst. Expect out_data stable, chan_read_incr=0 and burst_cnt frozen; on release the burst resumes with no loss or duplication.
- Early empty: ch2 holds 2 words, max_burst=4, ch3 holds data. Expect 2 words from ch2, then IDLE, then ch3 granted (rr_ptr=3).
- Disable plus wrap: num_channels=3, chan_enable=3'b101, all non-empty. Expect grants alternating 0,2,0,2 and ch1 never popped.
- Async reset asserted mid-burst. Expect out_valid=0, busy=0, chan_read_incr=0 immediately; after release, the first grant goes to the lowest eligible channel.
